// File: rtl/distance_pkg.sv
// Shared types and width/latency derivations for the distance pipeline.
package distance_pkg;

   typedef enum logic {
      METRIC_L2SQ = 1'b0,
      METRIC_L1   = 1'b1
   } metric_e;

   function automatic int out_w(input int dim, input int coord_w);
      return 2 * coord_w + $clog2(dim);
   endfunction

   function automatic int latency(input int dim);
      return 2 + $clog2(dim);
   endfunction

endpackage

// File: rtl/distance_pipe_sum_tree.sv
// Registered binary adder tree; one register level per halving, odd operands carried forward.
module sum_tree #(
   parameter int N     = 2,
   parameter int W     = 32,
   parameter int TAG_W = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     en,
   input  logic [N*W-1:0]           terms,
   input  logic                     term_valid,
   input  logic [TAG_W-1:0]         term_tag,
   output logic [W+$clog2(N)-1:0]   sum,
   output logic                     sum_valid,
   output logic [TAG_W-1:0]         sum_tag
);

   localparam int LVL  = $clog2(N);
   localparam int OW   = W + LVL;
   localparam int HALF = (N + 1) / 2;

   if (N < 2) begin : g_bad_n
      $error("sum_tree: N must be at least 2");
   end

   function automatic int cnt(input int l);
      return (N + (1 << l) - 1) >> l;
   endfunction

   // view[l] is the operand row entering level l; column N stays zero so pair reads never overrun.
   logic [OW-1:0]    view [0:LVL][0:N];
   logic [OW-1:0]    node [0:LVL-1][0:HALF-1];
   logic             vld  [0:LVL-1];
   logic [TAG_W-1:0] tag  [0:LVL-1];

   always_comb begin
      for (int l = 0; l <= LVL; l++)
         for (int i = 0; i <= N; i++)
            view[l][i] = '0;
      for (int i = 0; i < N; i++)
         view[0][i] = OW'(terms[i*W +: W]);
      for (int l = 1; l <= LVL; l++)
         for (int i = 0; i < HALF; i++)
            view[l][i] = node[l-1][i];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int l = 0; l < LVL; l++) begin
            vld[l] <= 1'b0;
            tag[l] <= '0;
            for (int i = 0; i < HALF; i++)
               node[l][i] <= '0;
         end
      end else if (en) begin
         vld[0] <= term_valid;
         tag[0] <= term_tag;
         for (int l = 1; l < LVL; l++) begin
            vld[l] <= vld[l-1];
            tag[l] <= tag[l-1];
         end
         for (int l = 0; l < LVL; l++)
            for (int i = 0; i < HALF; i++)
               if (2*i + 1 < cnt(l))
                  node[l][i] <= view[l][2*i] + view[l][2*i+1];
               else
                  node[l][i] <= view[l][2*i];
      end
   end

   assign sum       = node[LVL-1][0];
   assign sum_valid = vld[LVL-1];
   assign sum_tag   = tag[LVL-1];

endmodule

// File: rtl/distance_pipe.sv
// Pipelined vertex/query distance (squared L2 or L1) with valid/ready flow control.
module distance_pipe
   import distance_pkg::*;
#(
   parameter int DIM     = 2,
   parameter int COORD_W = 16,
   parameter int TAG_W   = 8
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            data_valid_in,
   output logic                            data_ready_out,
   input  logic [DIM*COORD_W-1:0]          vertex_pos_in,
   input  logic [DIM*COORD_W-1:0]          query_pos_in,
   input  logic                            metric_in,
   input  logic [TAG_W-1:0]                tag_in,
   output logic [out_w(DIM, COORD_W)-1:0]  distance_out,
   output logic [TAG_W-1:0]                tag_out,
   output logic                            data_valid_out,
   input  logic                            ready_in
);

   localparam int TW = 2 * COORD_W;

   if (DIM < 1 || DIM > 16) begin : g_bad_dim
      $error("distance_pipe: DIM must be in 1..16");
   end
   if (COORD_W < 1 || TAG_W < 1) begin : g_bad_width
      $error("distance_pipe: COORD_W and TAG_W must be positive");
   end

   logic en;
   assign en             = rst_in || !data_valid_out || ready_in;
   assign data_ready_out = en;

   // Difference at COORD_W+1 bits; its magnitude always fits back into COORD_W unsigned bits.
   logic [COORD_W:0]   diff    [DIM];
   logic [COORD_W:0]   neg     [DIM];
   logic [COORD_W-1:0] mag_nxt [DIM];

   always_comb begin
      for (int d = 0; d < DIM; d++) begin
         diff[d]    = {vertex_pos_in[d*COORD_W + COORD_W-1], vertex_pos_in[d*COORD_W +: COORD_W]}
                    - {query_pos_in[d*COORD_W + COORD_W-1],  query_pos_in[d*COORD_W +: COORD_W]};
         neg[d]     = -diff[d];
         mag_nxt[d] = diff[d][COORD_W] ? neg[d][COORD_W-1:0] : diff[d][COORD_W-1:0];
      end
   end

   logic [COORD_W-1:0] s1_mag [DIM];
   metric_e            s1_metric;
   logic [TAG_W-1:0]   s1_tag;
   logic               s1_vld;
   logic [DIM*TW-1:0]  s2_term;
   logic [TAG_W-1:0]   s2_tag;
   logic               s2_vld;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int d = 0; d < DIM; d++)
            s1_mag[d] <= '0;
         s1_metric <= METRIC_L2SQ;
         s1_tag    <= '0;
         s1_vld    <= 1'b0;
         s2_term   <= '0;
         s2_tag    <= '0;
         s2_vld    <= 1'b0;
      end else if (en) begin
         for (int d = 0; d < DIM; d++)
            s1_mag[d] <= mag_nxt[d];
         s1_metric <= metric_e'(metric_in);
         s1_tag    <= tag_in;
         s1_vld    <= data_valid_in;
         for (int d = 0; d < DIM; d++)
            s2_term[d*TW +: TW] <= (s1_metric == METRIC_L1) ? TW'(s1_mag[d])
                                                            : TW'(s1_mag[d]) * TW'(s1_mag[d]);
         s2_tag    <= s1_tag;
         s2_vld    <= s1_vld;
      end
   end

   if (DIM == 1) begin : g_direct
      assign distance_out   = s2_term;
      assign tag_out        = s2_tag;
      assign data_valid_out = s2_vld;
   end else begin : g_tree
      sum_tree #(
         .N     (DIM),
         .W     (TW),
         .TAG_W (TAG_W)
      ) u_sum_tree (
         .clk_in     (clk_in),
         .rst_in     (rst_in),
         .en         (en),
         .terms      (s2_term),
         .term_valid (s2_vld),
         .term_tag   (s2_tag),
         .sum        (distance_out),
         .sum_valid  (data_valid_out),
         .sum_tag    (tag_out)
      );
   end

endmodule

// File: tb/tb_distance_pipe.sv
// Directed bench for distance_pipe at DIM = 1, 2, 3 and 4.
module tb_distance_pipe;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic rst_in;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic        u1_valid, u1_ready, u1_metric, u1_dvo, u1_rdy;
   logic [15:0] u1_vtx, u1_qry;
   logic [7:0]  u1_tag, u1_tag_o;
   logic [31:0] u1_dist;

   logic        u2_valid, u2_ready, u2_metric, u2_dvo, u2_rdy;
   logic [31:0] u2_vtx, u2_qry;
   logic [7:0]  u2_tag, u2_tag_o;
   logic [32:0] u2_dist;

   logic        u3_valid, u3_ready, u3_metric, u3_dvo, u3_rdy;
   logic [47:0] u3_vtx, u3_qry;
   logic [7:0]  u3_tag, u3_tag_o;
   logic [33:0] u3_dist;

   logic        u4_valid, u4_ready, u4_metric, u4_dvo, u4_rdy;
   logic [63:0] u4_vtx, u4_qry;
   logic [7:0]  u4_tag, u4_tag_o;
   logic [33:0] u4_dist;

   distance_pipe #(.DIM(1)) u1 (
      .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(u1_valid), .data_ready_out(u1_ready),
      .vertex_pos_in(u1_vtx), .query_pos_in(u1_qry), .metric_in(u1_metric), .tag_in(u1_tag),
      .distance_out(u1_dist), .tag_out(u1_tag_o), .data_valid_out(u1_dvo), .ready_in(u1_rdy));
   distance_pipe #(.DIM(2)) u2 (
      .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(u2_valid), .data_ready_out(u2_ready),
      .vertex_pos_in(u2_vtx), .query_pos_in(u2_qry), .metric_in(u2_metric), .tag_in(u2_tag),
      .distance_out(u2_dist), .tag_out(u2_tag_o), .data_valid_out(u2_dvo), .ready_in(u2_rdy));
   distance_pipe #(.DIM(3)) u3 (
      .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(u3_valid), .data_ready_out(u3_ready),
      .vertex_pos_in(u3_vtx), .query_pos_in(u3_qry), .metric_in(u3_metric), .tag_in(u3_tag),
      .distance_out(u3_dist), .tag_out(u3_tag_o), .data_valid_out(u3_dvo), .ready_in(u3_rdy));
   distance_pipe #(.DIM(4)) u4 (
      .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(u4_valid), .data_ready_out(u4_ready),
      .vertex_pos_in(u4_vtx), .query_pos_in(u4_qry), .metric_in(u4_metric), .tag_in(u4_tag),
      .distance_out(u4_dist), .tag_out(u4_tag_o), .data_valid_out(u4_dvo), .ready_in(u4_rdy));

   int          sel;
   logic        sel_dvo;
   logic [63:0] sel_dist;
   logic [7:0]  sel_tag;

   always_comb begin
      sel_dvo  = 1'b0;
      sel_dist = '0;
      sel_tag  = '0;
      case (sel)
         1: begin sel_dvo = u1_dvo; sel_dist = 64'(u1_dist); sel_tag = u1_tag_o; end
         2: begin sel_dvo = u2_dvo; sel_dist = 64'(u2_dist); sel_tag = u2_tag_o; end
         3: begin sel_dvo = u3_dvo; sel_dist = 64'(u3_dist); sel_tag = u3_tag_o; end
         4: begin sel_dvo = u4_dvo; sel_dist = 64'(u4_dist); sel_tag = u4_tag_o; end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic logic [15:0] crd(input int k, input int d, input int s);
      int x;
      if (k % 13 == 0) return (s == 0) ? 16'h8000 : 16'h7FFF;
      x = k * 4513 + d * 977 + s * 7919 + 12345;
      return x[15:0];
   endfunction

   // Reference distance from plain integer arithmetic on 16-bit signed coordinates.
   function automatic logic [63:0] model(input logic [63:0] v, input logic [63:0] q,
                                         input logic m, input int dim);
      longint acc, a, b, df;
      acc = 0;
      for (int d = 0; d < dim; d++) begin
         a  = longint'($signed(v[d*16 +: 16]));
         b  = longint'($signed(q[d*16 +: 16]));
         df = (a > b) ? a - b : b - a;
         acc += m ? df : df * df;
      end
      return 64'(acc);
   endfunction

   task automatic drive(input int which, input logic vld, input logic [63:0] v, input logic [63:0] q,
                        input logic m, input logic [7:0] tg);
      case (which)
         1: begin u1_valid = vld; u1_vtx = v[15:0]; u1_qry = q[15:0]; u1_metric = m; u1_tag = tg; end
         2: begin u2_valid = vld; u2_vtx = v[31:0]; u2_qry = q[31:0]; u2_metric = m; u2_tag = tg; end
         3: begin u3_valid = vld; u3_vtx = v[47:0]; u3_qry = q[47:0]; u3_metric = m; u3_tag = tg; end
         default: begin u4_valid = vld; u4_vtx = v; u4_qry = q; u4_metric = m; u4_tag = tg; end
      endcase
   endtask

   task automatic single(input int which, input logic [63:0] v, input logic [63:0] q, input logic m,
                         input logic [7:0] tg, input logic [63:0] exp_d, input int exp_lat,
                         input string name);
      int n;
      sel = which;
      drive(which, 1'b1, v, q, m, tg);
      tick();
      drive(which, 1'b0, '0, '0, 1'b0, '0);
      n = 1;
      while (!sel_dvo && n < 12) begin
         tick();
         n++;
      end
      check({name, " latency"}, 64'(n), 64'(exp_lat));
      check({name, " distance"}, sel_dist, exp_d);
      check({name, " tag"}, 64'(sel_tag), 64'(tg));
      tick();
      check({name, " drained"}, 64'(sel_dvo), 64'd0);
   endtask

   logic [63:0] exp_d_q [$];
   logic [7:0]  exp_t_q [$];
   logic [63:0] v, q, hold_d;
   logic [7:0]  hold_t;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, got_n, first_c, last_c, sent, recv, bad;
      logic stalled;
      sel = 0;
      rst_in = 1'b1;
      u1_rdy = 1'b1; u2_rdy = 1'b1; u3_rdy = 1'b1; u4_rdy = 1'b1;
      for (int w = 1; w <= 4; w++) drive(w, 1'b0, '0, '0, 1'b0, '0);
      tick();
      tick();
      check("reset dvo", 64'(u2_dvo), 64'd0);
      check("reset distance", 64'(u2_dist), 64'd0);
      check("reset tag", 64'(u2_tag_o), 64'd0);
      check("reset ready", 64'(u4_ready), 64'd1);
      rst_in = 1'b0;
      tick();

      single(2, pk(3, 4, 0, 0), pk(0, 0, 0, 0), 1'b0, 8'h5A, 64'd25, 3, "d2 l2sq");
      single(3, pk(-5, 2, 7, 0), pk(1, -3, 7, 0), 1'b1, 8'h11, 64'd11, 4, "d3 l1");
      single(3, pk(-5, 2, 7, 0), pk(1, -3, 7, 0), 1'b0, 8'h22, 64'd61, 4, "d3 l2sq");
      single(2, pk(-32768, -32768, 0, 0), pk(32767, 32767, 0, 0), 1'b0, 8'hE1,
             64'd8589672450, 3, "d2 extreme l2sq");
      single(2, pk(-32768, -32768, 0, 0), pk(32767, 32767, 0, 0), 1'b1, 8'hE2,
             64'd131070, 3, "d2 extreme l1");
      single(1, pk(-7, 0, 0, 0), pk(5, 0, 0, 0), 1'b0, 8'h01, 64'd144, 2, "d1 l2sq");
      single(1, pk(-7, 0, 0, 0), pk(5, 0, 0, 0), 1'b1, 8'h02, 64'd12, 2, "d1 l1");

      // Mixed metrics back to back on the same pair.
      sel = 3;
      drive(3, 1'b1, pk(-5, 2, 7, 0), pk(1, -3, 7, 0), 1'b1, 8'hA1);
      tick();
      drive(3, 1'b1, pk(-5, 2, 7, 0), pk(1, -3, 7, 0), 1'b0, 8'hA2);
      tick();
      drive(3, 1'b0, '0, '0, 1'b0, '0);
      n = 0;
      while (!u3_dvo && n < 10) begin tick(); n++; end
      check("mixed first", u3_dist, 64'd11);
      check("mixed first tag", 64'(u3_tag_o), 64'hA1);
      tick();
      check("mixed second valid", 64'(u3_dvo), 64'd1);
      check("mixed second", u3_dist, 64'd61);
      tick();

      // 100-vector stream on DIM=4 with the consumer always ready.
      got_n = 0; first_c = -1; last_c = 0;
      for (int c = 0; c < 120; c++) begin
         if (c < 100) begin
            for (int d = 0; d < 4; d++) begin
               v[d*16 +: 16] = crd(c, d, 0);
               q[d*16 +: 16] = crd(c, d, 1);
            end
            drive(4, 1'b1, v, q, c[0], c[7:0]);
            exp_d_q.push_back(model(v, q, c[0], 4));
            exp_t_q.push_back(c[7:0]);
         end else begin
            drive(4, 1'b0, '0, '0, 1'b0, '0);
         end
         tick();
         if (u4_dvo) begin
            if (exp_d_q.size() == 0) begin
               check("stream extra", 64'd1, 64'd0);
            end else begin
               check("stream distance", u4_dist, exp_d_q.pop_front());
               check("stream tag", 64'(u4_tag_o), 64'(exp_t_q.pop_front()));
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            got_n++;
         end
      end
      check("stream count", 64'(got_n), 64'd100);
      check("stream first cycle", 64'(first_c), 64'd3);
      check("stream span", 64'(last_c - first_c), 64'd99);

      // Random backpressure: no loss, no duplication, outputs hold while stalled.
      sent = 0; recv = 0;
      for (int c = 0; c < 600 && recv < 30; c++) begin
         u4_rdy = 1'($urandom_range(0, 1));
         if (sent < 30) begin
            for (int d = 0; d < 4; d++) begin
               v[d*16 +: 16] = crd(sent + 200, d, 0);
               q[d*16 +: 16] = crd(sent + 200, d, 1);
            end
            drive(4, 1'b1, v, q, sent[1], 8'(sent + 100));
         end else begin
            drive(4, 1'b0, '0, '0, 1'b0, '0);
         end
         #1;
         if (u4_dvo && u4_rdy) begin
            if (exp_d_q.size() == 0) begin
               check("bp extra", 64'd1, 64'd0);
            end else begin
               check("bp distance", u4_dist, exp_d_q.pop_front());
               check("bp tag", 64'(u4_tag_o), 64'(exp_t_q.pop_front()));
            end
            recv++;
         end
         stalled = u4_dvo && !u4_rdy;
         hold_d  = 64'(u4_dist);
         hold_t  = u4_tag_o;
         if (u4_valid && u4_ready) begin
            exp_d_q.push_back(model(v, q, sent[1], 4));
            exp_t_q.push_back(8'(sent + 100));
            sent++;
         end
         @(posedge clk_in);
         #1;
         if (stalled)
            check("bp hold", {u4_dist, u4_tag_o, u4_dvo}, {hold_d[33:0], hold_t, 1'b1});
      end
      check("bp received", 64'(recv), 64'd30);
      check("bp leftover", 64'(exp_d_q.size()), 64'd0);
      u4_rdy = 1'b1;
      drive(4, 1'b0, '0, '0, 1'b0, '0);
      tick();
      tick();

      // Reset with three vectors in flight and the output stalled.
      u4_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(4, 1'b1, pk(k + 1, 2, 3, 4), pk(0, 0, 0, 0), 1'b0, 8'(k + 1));
         tick();
      end
      drive(4, 1'b0, '0, '0, 1'b0, '0);
      tick();
      check("stall valid", 64'(u4_dvo), 64'd1);
      check("stall ready", 64'(u4_ready), 64'd0);
      rst_in = 1'b1;
      drive(4, 1'b1, pk(9, 9, 9, 9), pk(0, 0, 0, 0), 1'b0, 8'h99);
      #1;
      check("reset ready while stalled", 64'(u4_ready), 64'd1);
      tick();
      rst_in = 1'b0;
      drive(4, 1'b0, '0, '0, 1'b0, '0);
      u4_rdy = 1'b1;
      check("mid reset dvo", 64'(u4_dvo), 64'd0);
      check("mid reset distance", 64'(u4_dist), 64'd0);
      check("mid reset tag", 64'(u4_tag_o), 64'd0);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (u4_dvo) bad++;
      end
      check("after reset no output", 64'(bad), 64'd0);
      single(4, pk(1, -2, 3, -4), pk(0, 0, 0, 0), 1'b0, 8'h33, 64'd30, 4, "d4 after reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/distance_pipe.md
DISTANCE_PIPE -- requirements
Module: distance_pipe

Interface
REQ-001 Parameter DIM, default 2: number of coordinate dimensions, legal range 1..16.
REQ-002 Parameter COORD_W, default 16: coordinate width, two's-complement signed.
REQ-003 Parameter TAG_W, default 8: width of the sideband tag that travels with each vector.
REQ-004 Derived constant OUT_W = 2*COORD_W + $clog2(DIM); LATENCY = 2 + $clog2(DIM) cycles.
REQ-005 Port clk_in, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 Port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port data_valid_in, input, 1 bit: the input vector pair is valid this cycle.
REQ-008 Port data_ready_out, output, 1 bit: the block accepts input this cycle.
REQ-009 Port vertex_pos_in, input, DIM x COORD_W signed: vertex coordinates.
REQ-010 Port query_pos_in, input, DIM x COORD_W signed: query coordinates.
REQ-011 Port metric_in, input, 1 bit: 0 = squared Euclidean, 1 = Manhattan (L1); sampled with each vector.
REQ-012 Port tag_in, input, TAG_W bits: sideband ID, passed through unchanged.
REQ-013 Port distance_out, output, OUT_W bits unsigned: the result.
REQ-014 Port tag_out, output, TAG_W bits: the tag of the result.
REQ-015 Port data_valid_out, output, 1 bit: distance_out and tag_out are valid.
REQ-016 Port ready_in, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-017 An input transfer occurs on a cycle where data_valid_in && data_ready_out; an output transfer occurs on a cycle where data_valid_out && ready_in.
REQ-018 Stage 1 registers |vertex[d] - query[d]| per dimension, computed at COORD_W+1 bits; the magnitude always fits in COORD_W unsigned bits.
REQ-019 Stage 2 registers the per-dimension term: the magnitude squared (2*COORD_W bits) if metric=0, or the magnitude zero-extended if metric=1.
REQ-020 Stages 3..LATENCY form a registered binary adder tree of $clog2(DIM) levels; with odd operand counts, the unpaired operand is carried forward through a register.
REQ-021 No intermediate or final value saturates or wraps: every legal input produces the exact result.
REQ-022 Metric and tag travel with their data through every stage; mixed metrics in flight are legal and each result uses its own metric.
REQ-023 Pipeline enable en = !data_valid_out || ready_in; all stage registers, valid bits included, advance only when en=1.
REQ-024 data_ready_out = en, combinationally; the data_valid_in to data_ready_out path is therefore absent.
REQ-025 Throughput is one result per cycle when ready_in is held high; latency is LATENCY cycles from input transfer to data_valid_out.
REQ-026 Bubbles (invalid stages) do not stall the pipeline; they are not compacted while the pipeline is stalled.
REQ-027 While data_valid_out=1 and ready_in=0, distance_out, tag_out and data_valid_out hold stable.
REQ-028 DIM=1 has no adder-tree stage: LATENCY = 2 and OUT_W = 2*COORD_W.
REQ-029 Extreme operands: COORD_W=16, vertex=-32768, query=32767 gives magnitude 65535 and square 4294836225.

Reset
REQ-030 While rst_in=1, all stage valid bits clear, distance_out=0, tag_out=0 and data_valid_out=0 on the next edge.
REQ-031 While rst_in=1, data_ready_out=1 (en=1); any input transfer on a reset cycle is discarded.
REQ-032 Reset asserted mid-operation drops all in-flight results; no partial result emerges afterwards.

Structure
REQ-033 Package distance_pkg holds the OUT_W and LATENCY derivation functions and the metric_e enum (METRIC_L2SQ=0, METRIC_L1=1).
REQ-034 The adder tree is a sub-module, sum_tree, parametrised by N operands and operand width, taking a shared enable and valid/tag sideband.
REQ-035 Parameters outside the legal range fail elaboration with $error.

Verification
REQ-036 DIM=2, COORD_W=16, metric=0: vertex (3,4), query (0,0), tag 0x5A -> distance 25, tag 0x5A, exactly 3 cycles after the transfer.
REQ-037 DIM=3, metric=1: vertex (-5,2,7), query (1,-3,7) -> distance 11, latency 4; the same pair with metric=0 -> 61.
REQ-038 DIM=4, a 100-vector back-to-back stream with ready_in=1 -> 100 results on consecutive cycles, in order, matching a reference model.
REQ-039 Random ready_in toggling at 50% -> no loss, no duplication, and outputs stable while stalled.
REQ-040 COORD_W=16, DIM=2, (-32768,-32768) versus (32767,32767), metric=0 -> 8589672450, no overflow.
REQ-041 rst_in pulsed for 1 cycle with 3 vectors in flight -> data_valid_out stays 0 until a new vector has been accepted and traversed the pipeline.
